// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional feature macro used by the design: IMEM_MISALIGN_TRAP_EN.
package imem_pkg;

   // Responder FSM: boot load, wait states before a read, serving a word.
   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WAIT  = 2'd1,
      SERVE = 2'd2
   } imem_state_t;

   // Word returned whenever no valid instruction is available.
   localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

   // Wait-state counter; holds 0..15 extra cycles per fetch.
   typedef logic [3:0] imem_wait_cnt_t;

   localparam int IMEM_WAIT_MAX = 15;

   // Converts the integer wait-state parameter to the counter type,
   // saturating so an out-of-range setting cannot wrap to a small value.
   function automatic imem_wait_cnt_t to_wait_cnt(input int cycles);
      if (cycles < 0) begin
         return '0;
      end
      if (cycles > IMEM_WAIT_MAX) begin
         return imem_wait_cnt_t'(IMEM_WAIT_MAX);
      end
      return imem_wait_cnt_t'(cycles);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM: synchronous write, synchronous registered read.
// One address serves both the boot-load write and the fetch read.
module imem_ram
   import imem_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] RESET_WORD = IMEM_NOP
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0] mem [0:DEPTH-1];

   // Write port: stores a boot-load word at the shared address.
   // NOTE: the storage array is deliberately not reset; clearing it would
   // prevent RAM inference and the contents must survive a reset anyway.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   // Read port: the output register is the responder's data register,
   // so it does take a reset value.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= RESET_WORD;
      end else if (rd_en) begin
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: boot-loads a RAM through a streaming port,
// then serves word fetches for the PC with WAIT_CYCLES extra wait states.
// imem_ready tells the hazard unit when imem_data is valid for imem_addr.
// Optional feature: define IMEM_MISALIGN_TRAP_EN to add imem_misalign,
// which flags (and blanks) fetches whose byte address is not word aligned.
module imem_responder
   import imem_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] NOP_WORD    = IMEM_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   output logic        imem_ready,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        boot_done
`ifdef IMEM_MISALIGN_TRAP_EN
   ,
   output logic        imem_misalign
`endif
);

   localparam imem_wait_cnt_t        WAIT_INIT = to_wait_cnt(WAIT_CYCLES);
   localparam logic [DEPTH_LOG2-1:0] LAST_PTR  = '1;

   imem_state_t           state;
   imem_state_t           state_nxt;
   logic [DEPTH_LOG2-1:0] load_ptr;
   imem_wait_cnt_t        wait_cnt;
   logic [31:0]           cur_addr;

   logic                  addr_match;
   logic                  load_fire;
   logic                  load_end;
   logic                  read_fire;
   logic [DEPTH_LOG2-1:0] ram_addr;
   logic [31:0]           ram_q;

   // The PC is compared at full width: any change is a new fetch, even if
   // it aliases to the same RAM word.
   assign addr_match = (imem_addr == cur_addr);

   // A load word is accepted only while loading.
   assign load_fire  = (state == LOAD) && load_valid;

   // Loading ends on the marked last word or when the RAM is full.
   assign load_end   = load_fire && (load_last || (load_ptr == LAST_PTR));

   // The RAM read is issued once the wait states for a stable address elapse.
   assign read_fire  = (state == WAIT) && addr_match && (wait_cnt == '0);

   // Shared RAM address: load pointer while booting, fetch word index after.
   assign ram_addr   = (state == LOAD) ? load_ptr : cur_addr[DEPTH_LOG2+1:2];

   imem_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .RESET_WORD (NOP_WORD)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (load_fire),
      .rd_en   (read_fire),
      .addr    (ram_addr),
      .wr_data (load_data),
      .rd_data (ram_q)
   );

   // State register; reset returns to boot loading.
   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the blocks are evaluated in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic for load -> wait -> serve and PC redirects.
   // NOTE: state_nxt is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_end)    state_nxt = WAIT;
         WAIT:    if (read_fire)   state_nxt = SERVE;
         SERVE:   if (!addr_match) state_nxt = WAIT;
         default:                  state_nxt = LOAD;
      endcase
   end

   // Load pointer, wait-state counter and latched fetch address.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_ptr <= '0;
         wait_cnt <= '0;
         cur_addr <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (load_fire) begin
                  load_ptr <= load_ptr + 1'b1;
               end
               if (load_end) begin
                  cur_addr <= imem_addr;
                  wait_cnt <= WAIT_INIT;
               end
            end
            WAIT: begin
               // A redirect while stalled restarts the wait from scratch.
               if (!addr_match) begin
                  cur_addr <= imem_addr;
                  wait_cnt <= WAIT_INIT;
               end else if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            SERVE: begin
               if (!addr_match) begin
                  cur_addr <= imem_addr;
                  wait_cnt <= WAIT_INIT;
               end
            end
            default: begin
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef IMEM_MISALIGN_TRAP_EN
   logic misalign_q;

   // Misalignment flag captured with the RAM read for the served address.
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (read_fire) begin
         misalign_q <= (cur_addr[1:0] != 2'b00);
      end
   end
`endif

   // Output decode: data and ready only in SERVE, load port only in LOAD.
   always_comb begin
      imem_data  = NOP_WORD;
      imem_ready = 1'b0;
      load_ready = 1'b0;
      boot_done  = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
      imem_misalign = 1'b0;
`endif
      case (state)
         LOAD: begin
            load_ready = 1'b1;
         end
         WAIT: begin
            boot_done = 1'b1;
         end
         SERVE: begin
            boot_done  = 1'b1;
            // Combinational compare so a PC change drops ready immediately.
            imem_ready = addr_match;
            imem_data  = ram_q;
`ifdef IMEM_MISALIGN_TRAP_EN
            if (misalign_q) begin
               imem_data     = NOP_WORD;
               imem_misalign = 1'b1;
            end
`endif
         end
         default: begin
            load_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed boot/fetch/redirect/alias/
// reset sequences with literal expectations, then randomized traffic checked
// every cycle against a fetch-timing model of the responder.
// Honours IMEM_MISALIGN_TRAP_EN when defined for the build.
module tb_imem_responder;

   localparam int          DEPTH_LOG2  = 10;
   localparam int          DEPTH       = 1 << DEPTH_LOG2;
   localparam int          WAIT_CYCLES = 1;
   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_ready;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        boot_done;
`ifdef IMEM_MISALIGN_TRAP_EN
   logic        imem_misalign;
`endif

   always #5 clk = ~clk;

   imem_responder #(
      .DEPTH_LOG2  (DEPTH_LOG2),
      .WAIT_CYCLES (WAIT_CYCLES),
      .NOP_WORD    (NOP_WORD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_ready (imem_ready),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .boot_done  (boot_done)
`ifdef IMEM_MISALIGN_TRAP_EN
      ,
      .imem_misalign (imem_misalign)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: RAM image, boot flag, load pointer and the cycle at
   // which the current fetch address was first presented.
   logic [31:0] mdl_mem [DEPTH];
   bit          booted = 1'b0;
   int          ptr    = 0;
   int          start  = 0;
   logic [31:0] fetch_addr = '0;

   // Output values sampled in the most recent cycle.
   logic [31:0] s_data;
   logic        s_ready, s_boot, s_lready;
`ifdef IMEM_MISALIGN_TRAP_EN
   logic        s_mis;
`endif

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   task automatic compare_cycle();
      logic        exp_ready;
      logic [31:0] exp_word;
      bit          exp_mis;
      if (booted && (imem_addr !== fetch_addr)) begin
         start      = cyc;
         fetch_addr = imem_addr;
      end
      exp_ready = booted && (cyc >= start + 2 + WAIT_CYCLES);
      exp_word  = mdl_mem[fetch_addr[DEPTH_LOG2+1:2]];
      exp_mis   = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
      if (fetch_addr[1:0] != 2'b00) begin
         exp_word = NOP_WORD;
         exp_mis  = 1'b1;
      end
`endif
      check("boot_done", s_boot, booted);
      check("load_ready", s_lready, !booted);
      check("imem_ready", s_ready, exp_ready);
      if (!booted) begin
         check("data_loading", s_data, NOP_WORD);
      end else if (exp_ready) begin
         check("data_served", s_data, exp_word);
      end else if (cyc > start) begin
         check("data_waiting", s_data, NOP_WORD);
      end
`ifdef IMEM_MISALIGN_TRAP_EN
      if (!booted || (cyc > start && !exp_ready)) begin
         check("misalign_idle", s_mis, 1'b0);
      end else if (exp_ready) begin
         check("misalign_served", s_mis, exp_mis);
      end
`else
      if (exp_mis) begin
         check("misalign_model", 32'd1, 32'd0);
      end
`endif
   endtask

   // Advance the model with this cycle's inputs.
   task automatic model_update();
      if (reset) begin
         booted = 1'b0;
         ptr    = 0;
      end else if (!booted && load_valid) begin
         mdl_mem[ptr] = load_data;
         if (load_last || ptr == DEPTH - 1) begin
            booted     = 1'b1;
            start      = cyc;
            fetch_addr = imem_addr;
         end
         ptr = (ptr + 1) % DEPTH;
      end
   endtask

   // One clock cycle: sample at the falling edge, compare, update model,
   // then return just after the next rising edge for the caller to drive.
   task automatic step();
      @(negedge clk);
      s_data   = imem_data;
      s_ready  = imem_ready;
      s_boot   = boot_done;
      s_lready = load_ready;
`ifdef IMEM_MISALIGN_TRAP_EN
      s_mis    = imem_misalign;
`endif
      if (!reset) begin
         compare_cycle();
      end
      model_update();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Present a new address and expect the word after exactly 2+WAIT_CYCLES
   // cycles of stall.
   task automatic fetch(input logic [31:0] a, input logic [31:0] word, input string name);
      imem_addr = a;
      repeat (2 + WAIT_CYCLES) begin
         step();
         check({name, "_stall"}, s_ready, 1'b0);
      end
      step();
      check({name, "_ready"}, s_ready, 1'b1);
      check({name, "_data"}, s_data, word);
   endtask

   logic [31:0] prog [4];

   initial begin
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0007;
      prog[2] = 32'h0109_5020;
      prog[3] = 32'hAC0A_0000;

      reset      = 1'b1;
      imem_addr  = '0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      repeat (2) step();
      reset = 1'b0;

      // Fill the whole RAM without load_last: boot must end on the last slot.
      for (int i = 0; i < DEPTH; i++) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         step();
      end
      load_valid = 1'b0;
      step();
      check("full_depth_boot", s_boot, 1'b1);
      repeat (4) step();

      // Reset, then boot the four-word program with PC held at 0.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 3);
         step();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      step();
      check("boot_after_last", s_boot, 1'b1);
      check("boot_ready_low", s_ready, 1'b0);
      step();
      check("boot_ready_low2", s_ready, 1'b0);
      step();
      check("boot_ready", s_ready, 1'b1);
      check("boot_word0", s_data, 32'h2008_0005);

      // Sequential fetch, then a redirect while stalled, then aliasing.
      fetch(32'h0000_0004, 32'h2009_0007, "seq4");
      fetch(32'h0000_0008, 32'h0109_5020, "seq8");
      imem_addr = 32'h0000_0004;
      step();
      check("redir_drop", s_ready, 1'b0);
      fetch(32'h0000_000C, 32'hAC0A_0000, "redir12");
      fetch(32'h0000_1004, 32'h2009_0007, "alias");

      // Reset while serving, reload a single word immediately.
      reset = 1'b1;
      step();
      reset      = 1'b0;
      imem_addr  = '0;
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      load_last  = 1'b1;
      step();
      check("rst_ready", s_ready, 1'b0);
      check("rst_boot", s_boot, 1'b0);
      check("rst_load_ready", s_lready, 1'b1);
      check("rst_data", s_data, NOP_WORD);
      load_valid = 1'b0;
      load_last  = 1'b0;
      step();
      check("reload_boot", s_boot, 1'b1);
      repeat (2) step();
      check("reload_ready", s_ready, 1'b1);
      check("reload_word", s_data, 32'hDEAD_BEEF);

`ifdef IMEM_MISALIGN_TRAP_EN
      fetch(32'h0000_0006, 32'h0000_0000, "mis6");
      check("mis6_flag", s_mis, 1'b1);
      fetch(32'h0000_0008, 32'h0109_5020, "mis8");
      check("mis8_flag", s_mis, 1'b0);
`endif

      // Randomized traffic: occasional resets, loads with random lengths,
      // ignored load attempts while serving, and random PC changes.
      for (int it = 0; it < 4000; it++) begin
         int r;
         reset      = ($urandom_range(0, 249) == 0);
         load_valid = $urandom_range(0, 1) != 0;
         load_data  = $urandom;
         load_last  = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 5) == 0) begin
            r = $urandom_range(0, 7);
            if (r == 7) begin
               imem_addr = $urandom;
            end else begin
               imem_addr = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 12);
            end
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
